// File: rtl/serial_parity_framer_pkg.sv
// ============================================================================
// serial_parity_framer_pkg : shared state encoding and parity helper
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none
package serial_parity_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PBIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  function automatic logic parity_of(input logic acc, input logic odd);
    return acc ^ odd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_parity_framer_parity_acc.sv
// ============================================================================
// parity_acc : 1-bit running XOR accumulator (clr loads d, en folds d in)
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none
module parity_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (clr) begin
      q <= d;
    end else if (en) begin
      q <= q ^ d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_parity_framer.sv
// ============================================================================
// serial_parity_framer : serial-to-parallel framer with even/odd parity and
//                        optional received-parity check, valid/ready on both sides
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none
module serial_parity_framer
  import serial_parity_framer_pkg::*;
#(
  parameter int FRAME_LEN  = 8,
  parameter int CNT_W      = 4,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_bit,
  output logic                 in_ready,
  input  logic                 check_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FRAME_LEN-1:0] out_data,
  output logic                 out_parity,
  output logic                 out_err,
  output logic                 busy
);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic                 chk_q;
  logic                 chk_d;
  logic                 err_q;
  logic                 par_q;
  logic                 acc_q;
  logic                 acc_d;
  logic [FRAME_LEN-1:0] data_q;
  logic                 frame_start;
  logic                 data_xfer;
  logic                 frame_done;

  assign in_ready  = (state_q != ST_HOLD);
  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_PBIT);

  assign frame_start = in_valid && (state_q == ST_IDLE);
  assign data_xfer   = in_valid && ((state_q == ST_IDLE) || (state_q == ST_SHIFT));
  assign cnt_d       = cnt_q + 1'b1;
  assign chk_d       = frame_start ? check_en : chk_q;
  // Parity including the bit being accepted now, so it can be latched on the final data edge.
  assign acc_d       = (frame_start ? 1'b0 : acc_q) ^ in_bit;
  assign frame_done  = data_xfer && (cnt_d == CNT_W'(FRAME_LEN));

  parity_acc u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (frame_start),
    .en    (data_xfer && !frame_start),
    .d     (in_bit),
    .q     (acc_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      chk_q   <= 1'b0;
      err_q   <= 1'b0;
      par_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_SHIFT: begin
          if (data_xfer) begin
            data_q <= (data_q << 1) | FRAME_LEN'(in_bit);
            cnt_q  <= cnt_d;
            chk_q  <= chk_d;
            if (frame_start) begin
              err_q <= 1'b0;
            end
            if (frame_done) begin
              par_q   <= parity_of(acc_d, ODD_PARITY);
              state_q <= chk_d ? ST_PBIT : ST_HOLD;
            end else begin
              state_q <= ST_SHIFT;
            end
          end
        end
        ST_PBIT: begin
          if (in_valid) begin
            err_q   <= (par_q != in_bit);
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_data   = data_q;
  assign out_parity = par_q;
  assign out_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_parity_framer.sv
// ============================================================================
// tb_serial_parity_framer : even/odd framers driven in lockstep against a
//                           frame-level model, plus a FRAME_LEN=1 instance
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none
module tb_serial_parity_framer;

  localparam int FL = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic in_valid = 1'b0, in_bit = 1'b0, check_en = 1'b0, out_ready = 1'b0;
  logic ir0, ov0, p0, e0, bz0;
  logic ir1, ov1, p1, e1, bz1;
  logic [FL-1:0] d0, d1;

  logic v2 = 1'b0, b2 = 1'b0, ce2 = 1'b0, r2 = 1'b0;
  logic ir2, ov2, p2, e2, bz2;
  logic [0:0] d2;

  serial_parity_framer #(.FRAME_LEN(FL), .CNT_W(4), .ODD_PARITY(1'b0)) u_even (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .in_ready(ir0),
    .check_en(check_en), .out_valid(ov0), .out_ready(out_ready), .out_data(d0),
    .out_parity(p0), .out_err(e0), .busy(bz0));

  serial_parity_framer #(.FRAME_LEN(FL), .CNT_W(4), .ODD_PARITY(1'b1)) u_odd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .in_ready(ir1),
    .check_en(check_en), .out_valid(ov1), .out_ready(out_ready), .out_data(d1),
    .out_parity(p1), .out_err(e1), .busy(bz1));

  serial_parity_framer #(.FRAME_LEN(1), .CNT_W(1), .ODD_PARITY(1'b0)) u_one (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_bit(b2), .in_ready(ir2),
    .check_en(ce2), .out_valid(ov2), .out_ready(r2), .out_data(d2),
    .out_parity(p2), .out_err(e2), .busy(bz2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: bits gathered so far, whether a parity bit is owed, and whether a result is held.
  int       m_n    = 0;
  bit [7:0] m_word = 8'h00;
  bit       m_chk  = 1'b0;
  bit       m_full = 1'b0;
  bit       m_err0 = 1'b0;
  bit       m_err1 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0; m_word = 8'h00; m_chk = 1'b0; m_full = 1'b0; m_err0 = 1'b0; m_err1 = 1'b0;
    end else if (m_full) begin
      if (out_ready) begin
        m_full = 1'b0;
        m_n    = 0;
      end
    end else if (in_valid) begin
      if (m_n == FL) begin
        m_err0 = ((^m_word) != in_bit);
        m_err1 = ((~^m_word) != in_bit);
        m_full = 1'b1;
      end else begin
        if (m_n == 0) begin
          m_chk = check_en; m_err0 = 1'b0; m_err1 = 1'b0;
        end
        m_word = 8'((m_word * 2) + in_bit);
        m_n++;
        if (m_n == FL && !m_chk) m_full = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready_even", ir0, !m_full);
      chk("in_ready_odd", ir1, !m_full);
      chk("out_valid_even", ov0, m_full);
      chk("out_valid_odd", ov1, m_full);
      chk("busy_even", bz0, (!m_full && m_n > 0));
      chk("busy_odd", bz1, (!m_full && m_n > 0));
      if (m_full) begin
        chk("data_even", d0, m_word);
        chk("data_odd", d1, m_word);
        chk("parity_even", p0, ^m_word);
        chk("parity_odd", p1, ~^m_word);
        chk("err_even", e0, m_err0);
        chk("err_odd", e1, m_err1);
      end
    end
  end

  task automatic cyc(input logic v, input logic b, input logic ce, input logic r);
    in_valid = v; in_bit = b; check_en = ce; out_ready = r;
    @(negedge clk);
  endtask

  // check_en is flipped after the first bit to confirm only the first sample matters.
  task automatic send(input logic [7:0] w, input logic ce, input logic haspar, input logic pb);
    for (int i = 7; i >= 0; i--) cyc(1'b1, w[i], (i == 7) ? ce : ~ce, 1'b0);
    if (haspar) cyc(1'b1, pb, ~ce, 1'b0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", ir0, 1'b1);
    chk("rst_out_valid", ov0, 1'b0);
    chk("rst_busy", bz0, 1'b0);
    chk("rst_data", d0, 8'h00);
    chk("rst_parity_odd", p1, 1'b0);
    chk("rst_err", e0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // FRAME_LEN=1: single bit goes straight to HOLD
    v2 = 1'b1; b2 = 1'b1;
    @(negedge clk);
    v2 = 1'b0;
    chk("len1_valid", ov2, 1'b1);
    chk("len1_data", d2, 1'b1);
    chk("len1_parity", p2, 1'b1);
    chk("len1_busy", bz2, 1'b0);
    chk("len1_in_ready", ir2, 1'b0);
    r2 = 1'b1;
    @(negedge clk);
    r2 = 1'b0;
    chk("len1_release", ir2, 1'b1);

    // 1,0,1,1,0,0,1,0 without check
    send(8'hB2, 1'b0, 1'b0, 1'b0);
    chk("b2_valid", ov0, 1'b1);
    chk("b2_data", d0, 8'hB2);
    chk("b2_parity_even", p0, 1'b0);
    chk("b2_parity_odd", p1, 1'b1);
    chk("b2_err", e0, 1'b0);
    chk("model_word", m_word, 8'hB2);
    repeat (5) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("hold_in_ready", ir0, 1'b0);
      chk("hold_data", d0, 8'hB2);
    end
    drain();
    chk("after_hs_in_ready", ir0, 1'b1);
    chk("after_hs_valid", ov0, 1'b0);

    send(8'hB2, 1'b1, 1'b1, 1'b0);
    chk("chk0_parity_odd", p1, 1'b1);
    chk("chk0_err_odd", e1, 1'b1);
    chk("chk0_err_even", e0, 1'b0);
    drain();
    send(8'hB2, 1'b1, 1'b1, 1'b1);
    chk("chk1_err_odd", e1, 1'b0);
    chk("chk1_err_even", e0, 1'b1);
    drain();

    // 8'hFF with the 1,0,0,1 valid pattern
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      if (i != 7) begin
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
      end
    end
    in_valid = 1'b0;
    chk("ff_valid", ov0, 1'b1);
    chk("ff_data", d0, 8'hFF);
    chk("ff_parity", p0, 1'b0);
    drain();

    // reset after 3 bits of 8'h5A
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", ov0, 1'b0);
    chk("mid_rst_busy", bz0, 1'b0);
    chk("mid_rst_in_ready", ir0, 1'b1);
    chk("mid_rst_data", d0, 8'h00);
    chk("mid_rst_parity", p0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h5A, 1'b0, 1'b0, 1'b0);
    chk("5a_data", d0, 8'h5A);
    chk("5a_parity", p0, 1'b0);
    drain();

    repeat (3000) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
          1'($urandom_range(0, 2) == 0));
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
